// File: rtl/blk_mem_arbiter.sv
// Two-requester arbiter in front of a simple dual-port block RAM: writes share port A,
// reads share port B, each with an independent round-robin pointer.
module blk_mem_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic                     r0_we,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0]    r0_wdata,
  output logic                     r0_rvalid,
  output logic [DATA_WIDTH-1:0]    r0_rdata,
  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic                     r1_we,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]    r1_wdata,
  output logic                     r1_rvalid,
  output logic [DATA_WIDTH-1:0]    r1_rdata,
  output logic                     mem_wea,
  output logic [ADDRESS_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0]    mem_dina,
  output logic [ADDRESS_WIDTH-1:0] mem_addrb,
  input  logic [DATA_WIDTH-1:0]    mem_doutb
);

  // r_wlast / r_rlast: index of the requester granted most recently on each port
  logic r_wlast, r_rlast;
  logic r_pend_vld, r_pend_own;
  logic r_bsel;

  logic w_wc0, w_wc1, w_rc0, w_rc1;
  logic w_wg0, w_wg1, w_rg0, w_rg1;
  logic w_rgnt, w_bsel;

  assign w_wc0 = r0_valid &  r0_we & ~rst;
  assign w_wc1 = r1_valid &  r1_we & ~rst;
  assign w_rc0 = r0_valid & ~r0_we & ~rst;
  assign w_rc1 = r1_valid & ~r1_we & ~rst;

  // On contention the requester that was not granted last wins
  assign w_wg0 = w_wc0 & (~w_wc1 |  r_wlast);
  assign w_wg1 = w_wc1 & (~w_wc0 | ~r_wlast);
  assign w_rg0 = w_rc0 & (~w_rc1 |  r_rlast);
  assign w_rg1 = w_rc1 & (~w_rc0 | ~r_rlast);

  assign r0_ready = w_wg0 | w_rg0;
  assign r1_ready = w_wg1 | w_rg1;

  assign mem_wea   = w_wg0 | w_wg1;
  assign mem_addra = w_wg1 ? r1_addr  : r0_addr;
  assign mem_dina  = w_wg1 ? r1_wdata : r0_wdata;

  // Port B keeps pointing at the last read winner when idle
  assign w_rgnt    = w_rg0 | w_rg1;
  assign w_bsel    = w_rgnt ? w_rg1 : r_bsel;
  assign mem_addrb = w_bsel ? r1_addr : r0_addr;

  assign r0_rvalid = r_pend_vld & ~r_pend_own & ~rst;
  assign r1_rvalid = r_pend_vld &  r_pend_own & ~rst;
  assign r0_rdata  = mem_doutb;
  assign r1_rdata  = mem_doutb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wlast    <= 1'b1;
      r_rlast    <= 1'b1;
      r_pend_vld <= 1'b0;
      r_pend_own <= 1'b0;
      r_bsel     <= 1'b0;
    end else begin
      if (w_wg0 | w_wg1) r_wlast <= w_wg1;
      if (w_rgnt) begin
        r_rlast <= w_rg1;
        r_bsel  <= w_rg1;
      end
      r_pend_vld <= w_rgnt;
      r_pend_own <= w_rg1;
    end
  end

endmodule
